div_ctrl: RTL and testbench

Sequential 4-bit unsigned restoring divider controller built around the team's combinational 4-bit subtractor `sub` (r = a - b mod 16).
- The controller owns the partial-remainder and quotient registers.
- Each iteration it decides whether to commit the subtractor result.
- It sequences W iterations per division and reports the result with a done pulse.
- It is the first sequential consumer of `sub` and serves as a simple arithmetic coprocessor for bench/top-level use.

---
 rtl/div_pkg.sv | 14 +
 rtl/sub.sv | 11 +
 rtl/div_ctrl.sv | 103 ++++++++++
 tb/tb_div_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the restoring divider controller.
// Pure declarations: no logic, no latency, no flow control.
package div_pkg;

  localparam int W  = 4;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub.sv
// Combinational 4-bit subtractor, r = a - b modulo 16.
// Zero latency; no flow control.
module sub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] r
);

  assign r = a - b;

endmodule

// File: rtl/div_ctrl.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per cycle, done pulses W+1 cycles after start.
// start is ignored while busy and accepted in IDLE or in the DONE cycle (back-to-back); no other backpressure.
module div_ctrl #(
  parameter int W = div_pkg::W
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  import div_pkg::*;

  if (W != 4) begin : g_w_check
    $error("div_ctrl: W must be 4 to match the sub datapath");
  end

  state_t        state, state_nxt;
  logic [W-1:0]  d_q, v_q, r_q, q_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    s;
  logic          s_ge;
  logic [W-1:0]  diff, r_nxt, q_nxt;
  logic          accept;

  // When S >= V the true difference is below V, so the low-bit subtract is exact.
  assign s      = {r_q, d_q[W-1]};
  assign s_ge   = (s >= {1'b0, v_q});
  assign r_nxt  = s_ge ? diff : s[W-1:0];
  assign q_nxt  = {q_q[W-2:0], s_ge};
  assign accept = start && (state != ST_RUN);

  sub u_sub (
    .a (s[W-1:0]),
    .b (v_q),
    .r (diff)
  );

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt_q == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = start ? ST_RUN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      d_q         <= '0;
      v_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d_q         <= dividend;
      v_q         <= divisor;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= CW'(W - 1);
      div_by_zero <= (divisor == '0);
    end else if (state == ST_RUN) begin
      d_q <= {d_q[W-2:0], 1'b0};
      r_q <= r_nxt;
      q_q <= q_nxt;
      if (cnt_q == '0) begin
        quotient  <= q_nxt;
        remainder <= r_nxt;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and exhaustive bench for div_ctrl with a result scoreboard.
module tb_div_ctrl;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } res_t;

  logic       ck;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  res_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  div_ctrl dut (
    .ck          (ck),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [3:0] a, input logic [3:0] b);
    res_t e;
    if (b == 4'd0) e = res_t'{4'hF, a, 1'b1};
    else           e = res_t'{a / b, a % b, 1'b0};
    return e;
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input res_t e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back(e);
  endtask

  // Waits for done (bounded), checks latency/busy and pops the scoreboard.
  task automatic wait_done(input bit drop, input int exp_lat, input string tag);
    int   n  = 0;
    int   nb = 0;
    res_t e;
    do begin
      @(negedge ck);
      if (drop && n == 0) start = 1'b0;
      n++;
      if (busy) nb++;
    end while (!done && n < 20);
    check({tag, " latency"}, 8'(n), 8'(exp_lat));
    check({tag, " busy cycles"}, 8'(nb), 8'(exp_lat - 1));
    check({tag, " busy in done cycle"}, {7'd0, busy}, 8'd0);
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s scoreboard: observed empty expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " quotient"},    {4'd0, quotient},    {4'd0, e.q});
      check({tag, " remainder"},   {4'd0, remainder},   {4'd0, e.r});
      check({tag, " div_by_zero"}, {7'd0, div_by_zero}, {7'd0, e.dbz});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},        {7'd0, busy},        8'd0);
    check({tag, " done"},        {7'd0, done},        8'd0);
    check({tag, " quotient"},    {4'd0, quotient},    8'd0);
    check({tag, " remainder"},   {4'd0, remainder},   8'd0);
    check({tag, " div_by_zero"}, {7'd0, div_by_zero}, 8'd0);
  endtask

  initial begin
    int  sweep_fail;
    bit  saw_done;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    #12;
    check_idle_outputs("reset");
    @(negedge ck);
    rst_n = 1'b1;
    @(negedge ck);

    drive(4'd13, 4'd3, res_t'{4'b0100, 4'b0001, 1'b0});
    wait_done(1'b1, 5, "13/3");

    drive(4'd15, 4'd1, res_t'{4'b1111, 4'b0000, 1'b0});
    wait_done(1'b1, 5, "15/1");
    @(negedge ck);
    check("15/1 done width", {7'd0, done}, 8'd0);
    drive(4'd2, 4'd9, res_t'{4'b0000, 4'b0010, 1'b0});
    wait_done(1'b1, 5, "2/9");
    @(negedge ck);
    check("2/9 done width", {7'd0, done}, 8'd0);

    drive(4'd7, 4'd0, res_t'{4'b1111, 4'b0111, 1'b1});
    wait_done(1'b1, 5, "7/0");
    drive(4'd6, 4'd2, res_t'{4'b0011, 4'b0000, 1'b0});
    wait_done(1'b1, 5, "6/2");

    // start held high; operand change during RUN must be ignored
    drive(4'd9, 4'd4, res_t'{4'b0010, 4'b0001, 1'b0});
    @(negedge ck);
    dividend = 4'd8;
    divisor  = 4'd8;
    exp_q.push_back(res_t'{4'b0001, 4'b0000, 1'b0});
    wait_done(1'b0, 4, "9/4 held");
    wait_done(1'b1, 5, "8/8 back-to-back");
    @(negedge ck);
    check("8/8 done width", {7'd0, done}, 8'd0);

    // reset asserted mid-run: immediate clear, no done pulse
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd5;
    @(negedge ck);
    start = 1'b0;
    @(posedge ck);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ck);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge ck);
    if (done) saw_done = 1'b1;
    check("aborted run done pulse", {7'd0, saw_done}, 8'd0);
    drive(4'd14, 4'd5, res_t'{4'b0010, 4'b0100, 1'b0});
    wait_done(1'b1, 5, "14/5 after reset");

    sweep_fail = n_fail;
    for (int dv = 0; dv < 16; dv++) begin
      for (int dd = 0; dd < 16; dd++) begin
        drive(4'(dd), 4'(dv), model(4'(dd), 4'(dv)));
        wait_done(1'b1, 5, $sformatf("sweep %0d/%0d", dd, dv));
      end
    end
    if (n_fail == sweep_fail) $display("exhaustive sweep OK");

    check("scoreboard drained", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
